uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 36 +++
 rtl/uart_link.sv | 204 ++++++++++++++++++++
 tb/tb_uart_link.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART link: transmit/receive FSM state encodings
// and the bit-period calculation used to size the baud counters.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clocks per serial bit, rounded down.
    function automatic int calc_period(input int clk_khz, input int bods);
        return (clk_khz * 32'sd1000) / bods;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts PERIOD clocks per tick while running, and can be
// preloaded so that the first tick lands half a period after the load.
module uart_baud_counter #(
    parameter int PERIOD = 16,
    parameter int CNT_W  = $clog2(PERIOD + 1)
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_run,
    input  logic i_load,
    input  logic i_half,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] C_ZERO       = CNT_W'(0);
    localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] C_HALF_START = CNT_W'(PERIOD - PERIOD / 2);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == C_LAST);

    // Period counter; wraps on every tick so consecutive bits stay aligned.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_cnt <= C_ZERO;
        end else if (i_load) begin
            r_cnt <= i_half ? C_HALF_START : C_ZERO;
        end else if (!i_run || o_tick) begin
            r_cnt <= C_ZERO;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_link.sv
// Full-duplex UART: 8N1-style transmitter and receiver sharing one clock,
// each timed by its own baud counter and running independently.
module uart_link
    import uart_pkg::*;
#(
    parameter int CLK_KHZ     = 100000,
    parameter int BODS        = 9600,
    parameter int DATA_AMOUNT = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   en_i,
    input  logic [DATA_AMOUNT-1:0] data_i,
    output logic                   ready_o,
    output logic                   tx_o,
    input  logic                   rx_i,
    output logic                   valid_data_o,
    output logic [DATA_AMOUNT-1:0] data_o
);

    localparam int P     = calc_period(CLK_KHZ, BODS);
    localparam int CNT_W = $clog2(P + 1);
    localparam int IDX_W = $clog2(DATA_AMOUNT + 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_AMOUNT - 1);
    localparam logic [IDX_W-1:0] C_IDX_ZERO = IDX_W'(0);
    localparam logic [DATA_AMOUNT-1:0] C_WORD_ZERO = DATA_AMOUNT'(0);

    tx_state_t              r_tx_state;
    logic [DATA_AMOUNT-1:0] r_tx_shift;
    logic [IDX_W-1:0]       r_tx_idx;
    logic                   r_tx;
    logic                   r_ready;
    logic                   w_tx_tick;
    logic                   w_tx_run;
    logic                   w_tx_load;

    rx_state_t              r_rx_state;
    logic [DATA_AMOUNT-1:0] r_rx_shift;
    logic [IDX_W-1:0]       r_rx_idx;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_prev;
    logic                   r_valid;
    logic [DATA_AMOUNT-1:0] r_data;
    logic                   w_rx_tick;
    logic                   w_rx_run;
    logic                   w_rx_fall;
    logic                   w_rx_load;

    assign w_tx_run  = (r_tx_state != TX_IDLE);
    assign w_tx_load = (r_tx_state == TX_IDLE) && en_i;
    assign w_rx_run  = (r_rx_state != RX_IDLE);
    assign w_rx_fall = r_rx_prev && !r_sync2;
    assign w_rx_load = (r_rx_state == RX_IDLE) && w_rx_fall;

    assign tx_o         = r_tx;
    assign ready_o      = r_ready;
    assign valid_data_o = r_valid;
    assign data_o       = r_data;

    uart_baud_counter #(.PERIOD(P), .CNT_W(CNT_W)) u_tx_baud (
        .i_clk    (clk_i),
        .i_arst_n (arst_i),
        .i_run    (w_tx_run),
        .i_load   (w_tx_load),
        .i_half   (1'b0),
        .o_tick   (w_tx_tick)
    );

    // RX counter is preloaded on the start edge so its first tick hits mid start bit.
    uart_baud_counter #(.PERIOD(P), .CNT_W(CNT_W)) u_rx_baud (
        .i_clk    (clk_i),
        .i_arst_n (arst_i),
        .i_run    (w_rx_run),
        .i_load   (w_rx_load),
        .i_half   (1'b1),
        .o_tick   (w_rx_tick)
    );

    // Transmit FSM; a request present when the stop bit ends chains the next frame.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= C_WORD_ZERO;
            r_tx_idx   <= C_IDX_ZERO;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (en_i) begin
                        r_tx_shift <= data_i;
                        r_tx       <= 1'b0;
                        r_ready    <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_AMOUNT-1:1]};
                        r_tx_idx   <= C_IDX_ZERO;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        if (r_tx_idx == C_LAST_IDX) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_AMOUNT-1:1]};
                            r_tx_idx   <= r_tx_idx + IDX_W'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        if (en_i) begin
                            r_tx_shift <= data_i;
                            r_tx       <= 1'b0;
                            r_tx_state <= TX_START;
                        end else begin
                            r_ready    <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx       <= 1'b1;
                    r_ready    <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Receive FSM; a low stop bit drops the word, and re-arming needs a fresh falling edge.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_rx_state <= RX_IDLE;
            r_rx_shift <= C_WORD_ZERO;
            r_rx_idx   <= C_IDX_ZERO;
            r_valid    <= 1'b0;
            r_data     <= C_WORD_ZERO;
        end else begin
            r_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_tick) begin
                        if (r_sync2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_idx   <= C_IDX_ZERO;
                            r_rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {r_sync2, r_rx_shift[DATA_AMOUNT-1:1]};
                        if (r_rx_idx == C_LAST_IDX) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + IDX_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        if (r_sync2) begin
                            r_data  <= r_rx_shift;
                            r_valid <= 1'b1;
                        end
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_link.sv
// Loopback bench for uart_link with a frame-level reference model; the bit
// period is shortened to 16 clocks so every scenario fits a short run.
module tb_uart_link;

    localparam int P     = 16;
    localparam int FRAME = 10;

    logic       clk  = 1'b0;
    logic       arst = 1'b0;
    logic       en   = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready_o;
    logic       tx_o;
    logic       rx_i;
    logic       valid_o;
    logic [7:0] data_o;

    logic loop_en = 1'b1;
    logic rx_drv  = 1'b1;
    assign rx_i = loop_en ? tx_o : rx_drv;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] m_data   = 8'h00;
    logic [9:0] m_frame  = 10'h3FF;
    int         m_remain = 0;
    logic       m_tx     = 1'b1;
    logic       m_ready  = 1'b1;
    logic [7:0] drv_word = 8'h00;
    int         drv_seq  = 0;
    int         seen_seq = 0;

    uart_link #(.CLK_KHZ(1000), .BODS(62500), .DATA_AMOUNT(8)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .en_i         (en),
        .data_i       (data),
        .ready_o      (ready_o),
        .tx_o         (tx_o),
        .rx_i         (rx_i),
        .valid_data_o (valid_o),
        .data_o       (data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame lasts FRAME*P clocks after acceptance, bit k covers
    // clocks [k*P, (k+1)*P); every accepted word in loopback must come back once.
    initial begin
        forever begin
            @(posedge clk);
            if (!arst) begin
                m_remain = 0;
                m_tx     = 1'b1;
                m_ready  = 1'b1;
                m_data   = 8'h00;
                rx_q.delete();
                seen_seq = drv_seq;
            end else begin
                if (m_remain > 0) m_remain--;
                if (m_remain == 0 && en) begin
                    m_frame  = {1'b1, data, 1'b0};
                    m_remain = FRAME * P;
                    if (loop_en) rx_q.push_back(data);
                end
                if (m_remain > 0) begin
                    m_tx    = m_frame[(FRAME * P - m_remain) / P];
                    m_ready = 1'b0;
                end else begin
                    m_tx    = 1'b1;
                    m_ready = 1'b1;
                end
                if (drv_seq != seen_seq) begin
                    rx_q.push_back(drv_word);
                    seen_seq = drv_seq;
                end
            end
            #1;
            check("tx_o", 32'(tx_o), 32'(m_tx));
            check("ready_o", 32'(ready_o), 32'(m_ready));
            if (valid_o) begin
                if (rx_q.size() == 0) begin
                    check("rx_strobe_unexpected", 32'(valid_o), 32'(0));
                end else begin
                    m_data = rx_q.pop_front();
                end
            end
            check("data_o", 32'(data_o), 32'(m_data));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        if (stop_bit) begin
            drv_word = d;
            drv_seq++;
        end
        rx_drv = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (P) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (P) @(negedge clk);
    endtask

    task automatic wait_drain(input int lim);
        int k;
        k = 0;
        while (rx_q.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("rx_drain", 32'(rx_q.size()), 32'(0));
    endtask

    initial begin
        logic [9:0] got;
        int         lo;
        int         nstr;

        // Reset held with a pending request.
        arst = 1'b0; en = 1'b1; data = 8'hFF;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx_o), 32'(1));
        check("rst_ready", 32'(ready_o), 32'(1));
        check("rst_valid", 32'(valid_o), 32'(0));
        check("rst_data", 32'(data_o), 32'(8'h00));
        arst = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame 0x72; data_i changes right after acceptance.
        data = 8'h72; en = 1'b1;
        @(negedge clk);
        en = 1'b0; data = 8'h00;
        got = 10'h000; lo = 0; nstr = 0;
        for (int j = 0; j < 12 * P; j++) begin
            if (!ready_o) lo++;
            if (valid_o) nstr++;
            for (int b = 0; b < FRAME; b++) begin
                if (j == P / 2 + b * P) got[b] = tx_o;
            end
            @(negedge clk);
        end
        check("bits_72", 32'(got), 32'(10'b1011100100));
        check("ready_low_72", 32'(lo), 32'(160));
        check("strobes_72", 32'(nstr), 32'(1));
        check("data_72", 32'(data_o), 32'(8'h72));

        // Request held for 12 bit periods: exactly two chained frames.
        data = 8'hA1; en = 1'b1; nstr = 0;
        for (int j = 0; j < 25 * P; j++) begin
            if (j == 12 * P) en = 1'b0;
            if (valid_o) begin
                nstr++;
                check("data_a1", 32'(data_o), 32'(8'hA1));
            end
            @(negedge clk);
        end
        check("strobes_a1", 32'(nstr), 32'(2));

        // Reset in the middle of data bit 4 of a 0x55 frame.
        data = 8'h55; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (5 * P + P / 2 - 1) @(negedge clk);
        arst = 1'b0;
        #1;
        check("abort_tx", 32'(tx_o), 32'(1));
        check("abort_ready", 32'(ready_o), 32'(1));
        check("abort_valid", 32'(valid_o), 32'(0));
        check("abort_data", 32'(data_o), 32'(8'h00));
        repeat (3) @(negedge clk);
        arst = 1'b1; en = 1'b1; data = 8'h3C;
        @(negedge clk);
        en = 1'b0;
        wait_drain(12 * P);
        check("data_3c", 32'(data_o), 32'(8'h3C));
        repeat (3 * P) @(negedge clk);

        // Short low glitch on the receive line must be rejected.
        loop_en = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        nstr = 0;
        for (int j = 0; j < 3 * P; j++) begin
            if (valid_o) nstr++;
            @(negedge clk);
        end
        check("glitch_strobes", 32'(nstr), 32'(0));
        send_frame(8'h96, 1'b1);
        wait_drain(4 * P);
        check("data_96", 32'(data_o), 32'(8'h96));

        // Framing error: stop bit low, line held low, then a good frame.
        send_frame(8'h81, 1'b0);
        repeat (2 * P) @(negedge clk);
        check("framing_hold", 32'(data_o), 32'(8'h96));
        rx_drv = 1'b1;
        repeat (2 * P) @(negedge clk);
        send_frame(8'h42, 1'b1);
        wait_drain(4 * P);
        check("data_42", 32'(data_o), 32'(8'h42));
        repeat (4) @(negedge clk);
        check("rx_queue_empty", 32'(rx_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
